ram_lsu: RTL and testbench
==========================

Name: ram_lsu

Overview:
Load/store initiator that drives the word-addressed data RAM (combinational read, write on clock edge when MemWrite is high) on behalf of the core.
- Accepts byte, halfword and word requests over a valid/ready handshake.
- Performs read-modify-write for sub-word stores and sign/zero-extends sub-word loads.
- Returns one response per request.
- Sits between the datapath's memory stage and the data RAM.

Parameters:
DEPTH, 1024, number of 32-bit words in the attached RAM; word indices at or above DEPTH are out of range.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_err  out  1  misaligned, out-of-range or illegal funct3
ram_address  out  32  word index to RAM (req_addr >> 2)
ram_data_in  out  32  write data to RAM
ram_MemWrite  out  1  RAM write enable
ram_data_out  in  32  RAM combinational read data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - req_ready=1 (derived from state). rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - ram_address=0, ram_data_in=0, ram_MemWrite=0.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - Request is accepted on req_valid && req_ready. Latch we, funct3, addr, wdata.
  - Error check on acceptance: misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0), addr[31:2] >= DEPTH, or funct3 not listed (stores accept only 000/001/010).
  - Error → RESP with rsp_err=1, rsp_rdata=0. No RAM access.
  - Load or sub-word store → RD. Word store → WR.
- RD (one cycle):
  - ram_address = latched word index.
  - Capture ram_data_out into a 32-bit register at the clock edge.
  - Load: format the captured word into rsp_rdata using lane addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend → RESP.
  - Sub-word store → WR.
- WR (one cycle):
  - ram_MemWrite=1. ram_address = word index.
  - ram_data_in = req_wdata for SW. For SB/SH, ram_data_in = captured word with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - → RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable.
  - On rsp_ready, → IDLE.
  - A new request is not accepted in the same cycle as the response handshake; req_ready rises the following cycle.
- Latency from acceptance edge to rsp_valid high:
  - LW/LH/LB/SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- ram_MemWrite:
  - Asserted for exactly one cycle per store and never for loads or errors.
  - Gated by !reset, so no RAM write occurs on an edge where reset is high.
- Outside RD/WR: ram_address holds its last value and ram_MemWrite=0.
- Reset mid-operation: the transaction is aborted and all outputs return to reset values on the next edge. No partial write and no response are produced.
- Width rules:
  - Word index = addr[31:2], zero-extended to 32 bits.
  - Sign extension replicates bit 7 (B) or bit 15 (H).
  - rsp_rdata upper bits are 0 for BU/HU.
- Held inputs: req_* may change after acceptance without effect.

Decomposition:
- Shared package ram_lsu_pkg:
  - State enum (IDLE, RD, WR, RESP).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Lane-width localparams.
- One combinational sub-module, ram_lsu_align:
  - Inputs: word, byte offset, funct3, wdata.
  - Outputs: extended load value and merged store word.
  - Used by both RD formatting and WR merging.

Test Plan:
- LW to 0x10 with RAM[4]=0xDEADBEEF, rsp_ready=1 → rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0, ram_MemWrite never high.
- LB to 0x13 and LBU to 0x13 with RAM[4]=0xDEADBEEF → rsp_rdata=0xFFFFFFDE and 0x000000DE respectively.
- SB wdata=0x00000055 to 0x11, RAM[4]=0xDEADBEEF → ram_MemWrite high exactly one cycle with ram_address=4 and ram_data_in=0xDEAD55EF; rsp 3 cycles after acceptance. Then SW 0x12345678 to 0x10 → write at cycle 1 after acceptance, RAM[4]=0x12345678.
- Errors: SH to 0x11, LW to 0x1002, and req_funct3=011 load → rsp_err=1, rsp_rdata=0, 1-cycle latency, no RAM write. Out-of-range LW to 0x1000 with DEPTH=1024 → rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata stable and req_ready=0 throughout; after rsp_ready=1, req_ready=1 on the next cycle.
- Reset during WR of an SB → ram_MemWrite=0 on that edge, RAM unchanged, next cycle all outputs at reset values with req_ready=1 and no response.

Source files
------------

// File: rtl/ram_lsu_pkg.sv
// ram_lsu_pkg: shared states, funct3 encodings, lane widths and request legality check
package ram_lsu_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int B_W = 8;
    localparam int H_W = 16;

    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic legal, mis;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
        mis = ((f3 == F3_H) || (f3 == F3_HU)) ? off[0] : (f3 == F3_W) ? (off != 2'b00) : 1'b0;
        return !legal || mis;
    endfunction

endpackage

// File: rtl/ram_lsu_align.sv
// ram_lsu_align: lane extraction with sign/zero extension for loads, lane merge for sub-word stores
module ram_lsu_align
    import ram_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [B_W-1:0] b;
    logic [H_W-1:0] h;

    always_comb begin
        b = word[{off, 3'b000} +: B_W];
        h = off[1] ? word[31:16] : word[15:0];
        load_val = (funct3 == F3_B)  ? {{(32-B_W){b[B_W-1]}}, b} :
                   (funct3 == F3_BU) ? {{(32-B_W){1'b0}}, b} :
                   (funct3 == F3_H)  ? {{(32-H_W){h[H_W-1]}}, h} :
                   (funct3 == F3_HU) ? {{(32-H_W){1'b0}}, h} : word;
        store_word = (funct3 == F3_W) ? wdata : word;
        if (funct3 == F3_B) store_word[{off, 3'b000} +: B_W] = wdata[B_W-1:0];
        if (funct3 == F3_H) store_word[{off[1], 4'b0000} +: H_W] = wdata[H_W-1:0];
    end

endmodule

// File: rtl/ram_lsu.sv
// ram_lsu: valid/ready load/store initiator for a word-addressed RAM with sub-word read-modify-write
module ram_lsu
    import ram_lsu_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    output logic        ram_MemWrite,
    input  logic [31:0] ram_data_out
);

    state_t      state_q, state_d;
    logic        we_q, we_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d;
    logic [31:0] rdata_q, rdata_d, ram_addr_q, ram_addr_d, din_q, din_d;
    logic [31:0] idx, load_val, store_word;
    logic        accept, bad;

    assign idx          = {2'b00, addr_q[31:2]};
    assign accept       = req_valid && req_ready;
    assign bad          = req_bad(req_we, req_funct3, req_addr[1:0]) ||
                          ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign ram_address  = ((state_q == RD) || (state_q == WR)) ? idx : ram_addr_q;
    assign ram_data_in  = (state_q == WR) ? store_word : din_q;
    assign ram_MemWrite = (state_q == WR) && !reset;

    // RD formats the live RAM word; WR merges into the word captured during RD
    ram_lsu_align u_align (
        .word       ((state_q == WR) ? word_q : ram_data_out),
        .off        (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ram_addr_d = ram_address;
        din_d      = ram_data_in;
        unique case (state_q)
            IDLE: if (accept) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = bad;
                state_d = bad ? RESP : (req_we && req_funct3 == F3_W) ? WR : RD;
            end
            RD: begin
                word_d  = ram_data_out;
                rdata_d = we_q ? '0 : load_val;
                state_d = we_q ? WR : RESP;
            end
            WR:   state_d = RESP;
            RESP: state_d = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ram_addr_q <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ram_addr_q <= ram_addr_d;
            din_q      <= din_d;
        end
    end

endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: directed and randomized checks of ram_lsu against a RAM model and a rule-level reference
module tb_ram_lsu;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err, ram_MemWrite;
    logic [31:0] rsp_rdata, ram_address, ram_data_in, ram_data_out;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int n_cmp = 0, n_fail = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          wcyc;
        logic        rdy;
    } obs_t;

    ram_lsu #(.DEPTH(1024)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_MemWrite(ram_MemWrite),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    assign ram_data_out = mem[ram_address[9:0]];
    always @(posedge clk) if (ram_MemWrite) mem[ram_address[9:0]] <= ram_data_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected outcome from the access rules alone; updates the reference RAM for stores.
    function automatic obs_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd);
        obs_t e;
        int unsigned idx, off, size;
        logic [31:0] w, v, mask;
        logic legal, bad;
        e = '{lat: 1, rdata: 0, err: 0, nwr: 0, waddr: 0, wdata: 0, wcyc: 0, rdy: 1};
        idx   = a >> 2;
        off   = a % 4;
        size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        bad   = !legal || (a % size != 0) || (idx >= 1024);
        e.err = bad;
        if (bad) return e;
        e.lat = (we && size < 4) ? 3 : 2;
        w = ref_mem[idx];
        if (!we) begin
            v = w >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            e.rdata = v;
        end else begin
            mask = (size == 1 ? 32'hFF : size == 2 ? 32'hFFFF : 32'hFFFF_FFFF) << (8 * off);
            e.nwr   = 1;
            e.waddr = idx;
            e.wdata = (w & ~mask) | ((wd << (8 * off)) & mask);
            e.wcyc  = (size == 4) ? 1 : 2;
            ref_mem[idx] = e.wdata;
        end
        return e;
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output obs_t o);
        int guard = 0;
        o = '{lat: -1, rdata: 0, err: 0, nwr: 0, waddr: 0, wdata: 0, wcyc: 0, rdy: 0};
        while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 8; k++) begin
            if (ram_MemWrite) begin o.nwr++; o.waddr = ram_address; o.wdata = ram_data_in; o.wcyc = k; end
            if (rsp_valid) begin o.lat = k; o.rdata = rsp_rdata; o.err = rsp_err; break; end
            @(posedge clk); #1;
        end
        if (o.lat > 0) begin @(posedge clk); #1; o.rdy = req_ready; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, ram_MemWrite, rsp_rdata, ram_address, ram_data_in}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 96'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b err=%b we=%b rdata=%h addr=%h din=%h, want 1 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, ram_MemWrite, rsp_rdata, ram_address, ram_data_in);
        end
        reset = 1'b0;
    endtask

    task automatic test_load();
        obs_t o, e;
        logic [2:0]  f3s [3] = '{3'b010, 3'b000, 3'b100};
        logic [31:0] as  [3] = '{32'h10, 32'h13, 32'h13};
        logic [31:0] exp [3] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE};
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f3s[i], as[i], 32'h0, o);
            e = model(1'b0, f3s[i], as[i], 32'h0);
            n_cmp++;
            if (o.rdata !== exp[i] || o.err !== 1'b0) begin
                n_fail++;
                $display("FAIL load_%0d: got rdata=%h err=%b, want %h 0", i, o.rdata, o.err, exp[i]);
            end
            n_cmp++;
            if (o.lat !== 2 || o.nwr !== 0 || o.rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_timing_%0d: got lat=%0d writes=%0d rdy=%b, want 2 0 1", i, o.lat, o.nwr, o.rdy);
            end
        end
    endtask

    task automatic test_store();
        obs_t o, e;
        do_req(1'b1, 3'b000, 32'h11, 32'h00000055, o);
        e = model(1'b1, 3'b000, 32'h11, 32'h00000055);
        n_cmp++;
        if (o.nwr !== 1 || o.waddr !== 32'd4 || o.wdata !== 32'hDEAD55EF || o.wcyc !== 2 || o.lat !== 3) begin
            n_fail++;
            $display("FAIL store_sb: got writes=%0d addr=%h data=%h wcyc=%0d lat=%0d, want 1 4 dead55ef 2 3",
                     o.nwr, o.waddr, o.wdata, o.wcyc, o.lat);
        end
        do_req(1'b1, 3'b010, 32'h10, 32'h12345678, o);
        e = model(1'b1, 3'b010, 32'h10, 32'h12345678);
        n_cmp++;
        if (o.nwr !== 1 || o.wcyc !== 1 || o.lat !== 2 || mem[4] !== 32'h12345678 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL store_sw: got writes=%0d wcyc=%0d lat=%0d ram4=%h rdata=%h, want 1 1 2 12345678 0",
                     o.nwr, o.wcyc, o.lat, mem[4], o.rdata);
        end
    endtask

    task automatic test_errors();
        obs_t o, e;
        logic        wes [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
        logic [31:0] as  [4] = '{32'h11, 32'h1002, 32'h10, 32'h1000};
        for (int i = 0; i < 4; i++) begin
            do_req(wes[i], f3s[i], as[i], 32'hFFFF_FFFF, o);
            e = model(wes[i], f3s[i], as[i], 32'hFFFF_FFFF);
            n_cmp++;
            if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.lat !== 1 || o.nwr !== 0) begin
                n_fail++;
                $display("FAIL error_%0d: got err=%b rdata=%h lat=%0d writes=%0d, want 1 0 1 0",
                         i, o.err, o.rdata, o.lat, o.nwr);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        logic ok = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        while (!rsp_valid && guard < 10) begin @(posedge clk); #1; guard++; end
        for (int k = 0; k < 5; k++) begin
            if (!rsp_valid || rsp_rdata !== ref_mem[4] || req_ready !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL backpressure_hold: got vld=%b rdata=%h rdy=%b, want 1 %h 0",
                     rsp_valid, rsp_rdata, req_ready, ref_mem[4]);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b, want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_write();
        logic seen = 1'b0;
        mem[8] = 32'hA5A5A5A5; ref_mem[8] = 32'hA5A5A5A5;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h3C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ram_MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_reaches_wr: got MemWrite=%b, want 1", ram_MemWrite);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ram_MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gates_write: got MemWrite=%b, want 0", ram_MemWrite);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, ram_MemWrite, rsp_rdata, ram_address, ram_data_in}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 96'h0} || mem[8] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL reset_abort: got rdy=%b vld=%b err=%b we=%b rdata=%h addr=%h din=%h ram8=%h, want 1 0 0 0 0 0 0 a5a5a5a5",
                     req_ready, rsp_valid, rsp_err, ram_MemWrite, rsp_rdata, ram_address, ram_data_in, mem[8]);
        end
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_response: got rsp_valid seen=%b, want 0", seen);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4200));
            wd = $urandom;
            do_req(we, f3, a, wd, o);
            e = model(we, f3, a, wd);
            n_cmp++;
            if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata || o.rdy !== e.rdy) begin
                n_fail++;
                $display("FAIL rand_%0d_rsp (we=%b f3=%b a=%h): got lat=%0d err=%b rdata=%h rdy=%b, want %0d %b %h %b",
                         i, we, f3, a, o.lat, o.err, o.rdata, o.rdy, e.lat, e.err, e.rdata, e.rdy);
            end
            n_cmp++;
            if (o.nwr !== e.nwr || o.waddr !== e.waddr || o.wdata !== e.wdata || o.wcyc !== e.wcyc) begin
                n_fail++;
                $display("FAIL rand_%0d_write (we=%b f3=%b a=%h): got n=%0d addr=%h data=%h cyc=%0d, want %0d %h %h %0d",
                         i, we, f3, a, o.nwr, o.waddr, o.wdata, o.wcyc, e.nwr, e.waddr, e.wdata, e.wcyc);
            end
        end
        for (int j = 0; j < 1024; j += 97) begin
            n_cmp++;
            if (mem[j] !== ref_mem[j]) begin
                n_fail++;
                $display("FAIL ram_contents[%0d]: got %h, want %h", j, mem[j], ref_mem[j]);
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 1024; j++) begin
            mem[j] = $urandom;
            ref_mem[j] = mem[j];
        end
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
